note_highway_sequencer: RTL and testbench

- Drives the song-ROM note index at a programmable tempo.
- Captures each returned 5-lane note word into a shift-register "highway" of ROWS rows.
- Presents the highway to the renderer and the bottom (hit) row to the scoring logic.
- Sits directly upstream of the song-note ROM (7-bit index in, registered 5-bit note out, one-cycle read latency) and owns song start, pause, stop and end-of-song.

---
 rtl/gh_pkg.sv | 17 +
 rtl/beat_timer.sv | 28 ++
 rtl/note_highway_sequencer.sv | 119 +++++++++++
 tb/tb_note_highway_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gh_pkg.sv
// Shared types for the note-highway sequencer.
// Lane count, ROM index width and the sequencer state set.
package gh_pkg;

   localparam int LANES  = 5;
   localparam int ADDR_W = 7;

   typedef logic [LANES-1:0] note_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/beat_timer.sv
// Free-running tick counter with enable and clear.
// wrap is high on the enabled cycle whose edge rolls the count to zero.
module beat_timer #(
   parameter int TICKS = 2_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic wrap
);

   localparam int TW = $clog2(TICKS);

   logic [TW-1:0] cnt;

   assign wrap = en && (cnt == TW'(TICKS - 1));

   // count enabled cycles, folding back to zero on the last tick
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/note_highway_sequencer.sv
// Steps the song ROM at the beat rate and shifts notes down the highway.
// Row 0 is the newest note; row ROWS-1 is the strike line.
module note_highway_sequencer
   import gh_pkg::*;
#(
   parameter int TICKS_PER_BEAT = 2_500_000,
   parameter int ROWS           = 8,
   parameter int SONG_LEN       = 94
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    stop,
   output logic [ADDR_W-1:0]       rom_addr,
   input  note_t                   rom_data,
   output logic                    beat,
   output logic [LANES*ROWS-1:0]   lane_rows,
   output note_t                   hit_row,
   output logic                    busy,
   output logic                    done
);

   localparam int FED_W = $clog2(SONG_LEN + 1);
   localparam int FLU_W = $clog2(ROWS + 1);

   seq_state_t       state;
   logic [FED_W-1:0] fed;
   logic [FLU_W-1:0] flush;
   note_t            rows [ROWS];

   logic active;
   logic run;
   logic wrap;
   logic fed_full;
   logic last_beat;

   assign active    = (state == PLAY) || (state == PAUSE);
   // a cycle with pause low in PLAY/PAUSE advances the tempo,
   // so the beat is delayed by exactly the number of paused cycles
   assign run       = active && !pause && !stop && !start;
   assign fed_full  = (fed == FED_W'(SONG_LEN));
   assign last_beat = wrap && fed_full
                   && (flush == FLU_W'(ROWS - 1));

   beat_timer #(
      .TICKS (TICKS_PER_BEAT)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (stop | start),
      .en   (run),
      .wrap (wrap)
   );

   // state, ROM index, fed/flush counters and the beat pulse
   always_ff @(posedge clk) begin
      if (rst || stop) begin
         state    <= IDLE;
         rom_addr <= '0;
         fed      <= '0;
         flush    <= '0;
         beat     <= 1'b0;
      end else if (start) begin
         state    <= PLAY;
         rom_addr <= '0;
         fed      <= '0;
         flush    <= '0;
         beat     <= 1'b0;
      end else begin
         beat <= wrap;
         unique case (state)
            PLAY, PAUSE: begin
               if (pause) begin
                  state <= PAUSE;
               end else if (last_beat) begin
                  state <= DONE;
               end else begin
                  state <= PLAY;
               end
            end
            default: state <= state;
         endcase
         if (wrap) begin
            if (!fed_full) begin
               fed <= fed + 1'b1;
            end else begin
               flush <= flush + 1'b1;
            end
            if (rom_addr < ADDR_W'(SONG_LEN - 1)) begin
               rom_addr <= rom_addr + 1'b1;
            end
         end
      end
   end

   // highway shift register: new note enters row 0 on each beat
   always_ff @(posedge clk) begin
      if (rst || stop || start) begin
         for (int r = 0; r < ROWS; r++) begin
            rows[r] <= '0;
         end
      end else if (wrap) begin
         rows[0] <= fed_full ? '0 : rom_data;
         for (int r = 1; r < ROWS; r++) begin
            rows[r] <= rows[r-1];
         end
      end
   end

   for (genvar g = 0; g < ROWS; g++) begin : g_pack
      assign lane_rows[LANES*g +: LANES] = rows[g];
   end

   assign hit_row = rows[ROWS-1];
   assign busy    = active;
   assign done    = (state == DONE);

endmodule

// File: tb/tb_note_highway_sequencer.sv
// Bench for note_highway_sequencer: directed song scenarios plus
// random start/stop/pause traffic against a beat-level song model.
module tb_note_highway_sequencer;

   localparam int T  = 4;
   localparam int R  = 4;
   localparam int SL = 6;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_HOLD  = 2;
   localparam int M_DONE  = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           pause = 1'b0;
   logic           stop = 1'b0;
   logic [6:0]     rom_addr;
   logic [4:0]     rom_data = '0;
   logic           beat;
   logic [5*R-1:0] lane_rows;
   logic [4:0]     hit_row;
   logic           busy;
   logic           done;

   int checks = 0;
   int fails  = 0;

   note_highway_sequencer #(
      .TICKS_PER_BEAT (T),
      .ROWS           (R),
      .SONG_LEN       (SL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pause     (pause),
      .stop      (stop),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .beat      (beat),
      .lane_rows (lane_rows),
      .hit_row   (hit_row),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] rom_at(int a);
      case (a)
         0: return 5'b00001;
         1: return 5'b00010;
         2: return 5'b00100;
         3: return 5'b01000;
         4: return 5'b10000;
         5: return 5'b00011;
         default: return 5'b00000;
      endcase
   endfunction

   // registered song ROM, one-cycle latency
   always @(posedge clk) rom_data <= rom_at(int'(rom_addr));

   // song model: tempo measured in unpaused cycles, notes as a list
   int         m_mode = M_IDLE;
   int         m_tick = 0;
   int         m_addr = 0;
   int         m_fed  = 0;
   int         m_flush = 0;
   logic       m_beat = 1'b0;
   logic [4:0] m_rd = '0;
   logic [4:0] m_rows [R];
   logic [4:0] old_rd;

   task automatic model_clear(int mode);
      m_mode  = mode;
      m_tick  = 0;
      m_addr  = 0;
      m_fed   = 0;
      m_flush = 0;
      m_beat  = 1'b0;
      for (int r = 0; r < R; r++) m_rows[r] = '0;
   endtask

   task automatic model_beat(logic [4:0] rd);
      for (int r = R - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
      if (m_fed < SL) begin
         m_rows[0] = rd;
         m_fed++;
      end else begin
         m_rows[0] = '0;
         m_flush++;
         if (m_flush == R) m_mode = M_DONE;
      end
      if (m_addr < SL - 1) m_addr++;
      m_beat = 1'b1;
   endtask

   initial model_clear(M_IDLE);

   always @(posedge clk) begin
      old_rd = m_rd;
      m_rd   = rom_at(m_addr);
      if (rst || stop) begin
         model_clear(M_IDLE);
      end else if (start) begin
         model_clear(M_RUN);
      end else if (m_mode == M_RUN || m_mode == M_HOLD) begin
         m_beat = 1'b0;
         if (pause) begin
            m_mode = M_HOLD;
         end else begin
            m_mode = M_RUN;
            m_tick++;
            if (m_tick == T) begin
               m_tick = 0;
               model_beat(old_rd);
            end
         end
      end else begin
         m_beat = 1'b0;
      end
   end

   function automatic logic [5*R-1:0] m_lanes();
      logic [5*R-1:0] v;
      v = '0;
      for (int r = 0; r < R; r++) v[5*r +: 5] = m_rows[r];
      return v;
   endfunction

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("rom_addr", rom_addr, 128'(m_addr));
      chk("lane_rows", lane_rows, m_lanes());
      chk("hit_row", hit_row, m_rows[R-1]);
      chk("beat", beat, m_beat);
      chk("busy", busy, (m_mode == M_RUN || m_mode == M_HOLD));
      chk("done", done, (m_mode == M_DONE));
   endtask

   task automatic wait_beat(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!beat && n < 64);
      if (!beat) chk("beat_timeout", 0, 1);
   endtask

   int         n;
   int         saw;
   logic [6:0] sv_addr;
   logic [5*R-1:0] sv_rows;

   initial begin
      step();
      step();
      rst = 1'b0;
      chk("rst_addr", rom_addr, 0);
      chk("rst_rows", lane_rows, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", busy, 1);
      wait_beat(n);
      chk("first_gap", n, 4);
      chk("b1_row0", lane_rows[4:0], 5'b00001);
      chk("b1_addr", rom_addr, 1);
      for (int i = 0; i < 3; i++) begin
         wait_beat(n);
         chk("gap", n, 4);
      end
      chk("b4_hit", hit_row, 5'b00001);
      chk("b4_row0", lane_rows[4:0], 5'b01000);
      for (int i = 0; i < 2; i++) wait_beat(n);
      chk("b6_addr", rom_addr, 5);
      for (int i = 0; i < 4; i++) begin
         wait_beat(n);
         chk("flush_done_early", done, (i == 3));
      end
      chk("b10_done", done, 1);
      chk("b10_busy", busy, 0);
      chk("b10_rows", lane_rows, 0);
      chk("b10_addr", rom_addr, 5);

      start = 1'b1;
      step();
      start = 1'b0;
      wait_beat(n);
      chk("replay_gap", n, 4);
      chk("replay_row0", lane_rows[4:0], 5'b00001);

      step();
      step();
      sv_addr = rom_addr;
      sv_rows = lane_rows;
      saw = 0;
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (beat) saw++;
      end
      pause = 1'b0;
      chk("pause_beats", saw, 0);
      chk("pause_addr", rom_addr, sv_addr);
      chk("pause_rows", lane_rows, sv_rows);
      wait_beat(n);
      chk("resume_gap", n, 2);

      wait_beat(n);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_addr", rom_addr, 0);
      chk("stop_rows", lane_rows, 0);
      saw = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (beat) saw++;
      end
      chk("stop_quiet", saw, 0);

      start = 1'b1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      start = 1'b0;
      chk("rst_start_busy", busy, 0);

      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      stop = 1'b1;
      start = 1'b1;
      step();
      stop = 1'b0;
      start = 1'b0;
      chk("stop_start_busy", busy, 0);
      chk("stop_start_addr", rom_addr, 0);

      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 79) == 0);
         stop  = ($urandom_range(0, 299) == 0);
         rst   = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 24) == 0) pause = ~pause;
         step();
      end
      start = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
      pause = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
